// File: rtl/truth_table_prober.sv
// Sweeps all 2^N input vectors into a combinational block, captures its output
// into a truth-table word and reports the lowest-index mismatch against a reference.
module truth_table_prober #(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [(1<<N_INPUTS)-1:0] expected_table,
  input  logic                     dut_out,
  output logic [N_INPUTS-1:0]      probe_inp,
  output logic                     busy,
  output logic                     done,
  output logic [(1<<N_INPUTS)-1:0] table_out,
  output logic                     table_valid,
  output logic                     mismatch,
  output logic [N_INPUTS-1:0]      fail_index
);

  localparam int W = 1 << N_INPUTS;
  localparam logic [N_INPUTS:0] LAST_IDX = (N_INPUTS+1)'(W - 1);
  localparam logic [7:0]        SETTLE   = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_INPUTS:0] idx_q;
  logic [N_INPUTS:0] next_idx;
  logic [7:0]        cnt_q;
  logic [W-1:0]      exp_q;
  logic [W-1:0]      diff;
  logic [N_INPUTS-1:0] first_idx;
  logic              accept, sample, finish;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          sample = 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign next_idx = idx_q + 1'b1;
  assign diff     = table_out ^ exp_q;

  // Scan from the top so the lowest differing bit wins.
  always_comb begin
    first_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (diff[i]) first_idx = N_INPUTS'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      probe_inp   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_out   <= '0;
      table_valid <= 1'b0;
      mismatch    <= 1'b0;
      fail_index  <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (accept) begin
        idx_q       <= '0;
        probe_inp   <= '0;
        cnt_q       <= SETTLE;
        exp_q       <= expected_table;
        busy        <= 1'b1;
        table_valid <= 1'b0;
        table_out   <= '0;
        mismatch    <= 1'b0;
        fail_index  <= '0;
      end
      if (state_q == HOLD) begin
        if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          table_out[idx_q[N_INPUTS-1:0]] <= dut_out;
          if (idx_q != LAST_IDX) begin
            idx_q     <= next_idx;
            probe_inp <= next_idx[N_INPUTS-1:0];
            cnt_q     <= SETTLE;
          end
        end
      end
      if (finish) begin
        done        <= 1'b1;
        busy        <= 1'b0;
        table_valid <= 1'b1;
        mismatch    <= |diff;
        fail_index  <= first_idx;
      end
    end
  end

endmodule
